// File: rtl/ssp_peripheral_pkg.sv
// Shared definitions for the SSP peripheral: word width, gap limits and
// the TX/RX state enumerations.
package ssp_pkg;

    localparam int unsigned SSP_WORD_W        = 8;
    localparam int unsigned SSP_CNT_W         = 3;
    localparam int unsigned SSP_FRAME_GAP_MAX = 15;
    localparam int unsigned SSP_GAP_W         = 4;

    typedef enum logic [1:0] {
        TIDLE,
        TSHIFT,
        TGAP
    } ssp_tx_state_e;

    typedef enum logic {
        RIDLE,
        RSHIFT
    } ssp_rx_state_e;

endpackage

// File: rtl/ssp_peripheral_if.sv
// Serial-link and host-handshake signals of the SSP peripheral.
// The slave modport is the peripheral's view; master is the SSP master/host side.
interface ssp_peripheral_if;
    import ssp_pkg::*;

    // serial link from the SSP master
    logic                  SSPCLKOUT;
    logic                  SSPFSSOUT;
    logic                  SSPTXD;
    logic                  SSPOE_B;
    // serial link back to the SSP master
    logic                  SSPCLKIN;
    logic                  SSPFSSIN;
    logic                  SSPRXD;
    // host transmit handshake
    logic [SSP_WORD_W-1:0] TXBYTE;
    logic                  TXVALID;
    logic                  TXREADY;
    // host receive handshake
    logic [SSP_WORD_W-1:0] RXBYTE;
    logic                  RXVALID;
    logic                  RXACK;

    modport slave (
        input  SSPCLKOUT, SSPFSSOUT, SSPTXD, SSPOE_B, TXBYTE, TXVALID, RXACK,
        output SSPCLKIN, SSPFSSIN, SSPRXD, TXREADY, RXBYTE, RXVALID
    );

    modport master (
        output SSPCLKOUT, SSPFSSOUT, SSPTXD, SSPOE_B, TXBYTE, TXVALID, RXACK,
        input  SSPCLKIN, SSPFSSIN, SSPRXD, TXREADY, RXBYTE, RXVALID
    );

endinterface

// File: rtl/ssp_edge_detect.sv
// Registers the incoming SSP master clock and produces one-PCLK rise/fall strobes.
module ssp_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sclk_i,
    output logic rise_o,
    output logic fall_o
);

    logic sclk_q;

    // Previous-cycle copy of the serial clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sclk_q <= 1'b0;
        else         sclk_q <= sclk_i;
    end

    assign rise_o = sclk_i & ~sclk_q;
    assign fall_o = ~sclk_i & sclk_q;

endmodule

// File: rtl/ssp_peripheral.sv
// SSP slave peripheral: one-byte TX holding register feeding a framed serial
// transmitter clocked at PCLK/2, and a framed serial receiver sampling the
// master's clock on its falling edge.
// Optional feature macro: SSP_PERIPH_RXOVR_EN adds the sticky RXOVR flag.
module ssp_peripheral
    import ssp_pkg::*;
#(
    parameter int unsigned FRAME_GAP = 0
) (
    input  logic            PCLK,
    input  logic            CLEAR_B,
    ssp_peripheral_if.slave bus
`ifdef SSP_PERIPH_RXOVR_EN
    ,
    output logic            RXOVR
`endif
);

    localparam logic [SSP_GAP_W-1:0] GAP_LOAD =
        (FRAME_GAP > 0) ? SSP_GAP_W'(FRAME_GAP - 1) : '0;

    // transmit path state
    ssp_tx_state_e         tx_state_q, tx_state_d;
    logic                  clkin_q;
    logic [SSP_WORD_W-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic [SSP_WORD_W-2:0] tx_sh_q, tx_sh_d;
    logic [SSP_CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [SSP_GAP_W-1:0]  gap_q, gap_d;
    logic                  fss_q, fss_d;
    logic                  rxd_q, rxd_d;
    logic                  tx_edge, tx_load, tx_capture;

    // receive path state
    ssp_rx_state_e         rx_state_q, rx_state_d;
    logic [SSP_WORD_W-2:0] rx_sh_q, rx_sh_d;
    logic [SSP_CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [SSP_WORD_W-1:0] rxbyte_q, rxbyte_d;
    logic                  rxvalid_q, rxvalid_d;
    logic                  rx_complete;
    logic                  sample;
    logic                  sclk_rise_unused;

    ssp_edge_detect u_edge (
        .clk_i  (PCLK),
        .rst_ni (CLEAR_B),
        .sclk_i (bus.SSPCLKOUT),
        .rise_o (sclk_rise_unused),
        .fall_o (sample)
    );

    assign tx_edge    = ~clkin_q;
    assign tx_capture = bus.TXVALID & ~hold_full_q;
    assign hold_full_d = (hold_full_q & ~tx_load) | tx_capture;
    assign hold_d      = tx_capture ? bus.TXBYTE : hold_q;

    // TX next-state: frame start, bit shifting and inter-frame gap.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_sh_d    = tx_sh_q;
        tx_cnt_d   = tx_cnt_q;
        gap_d      = gap_q;
        fss_d      = fss_q;
        rxd_d      = rxd_q;
        tx_load    = 1'b0;
        if (tx_edge) begin
            case (tx_state_q)
                TIDLE: tx_load = hold_full_q;
                TSHIFT: begin
                    if (tx_cnt_q != '0) begin
                        rxd_d    = tx_sh_q[SSP_WORD_W-2];
                        tx_sh_d  = {tx_sh_q[SSP_WORD_W-3:0], 1'b0};
                        fss_d    = 1'b0;
                        tx_cnt_d = tx_cnt_q - 1'b1;
                    end else if (hold_full_q && FRAME_GAP == 0) begin
                        tx_load = 1'b1;
                    end else begin
                        fss_d      = 1'b0;
                        rxd_d      = 1'b0;
                        tx_state_d = (FRAME_GAP == 0) ? TIDLE : TGAP;
                        gap_d      = GAP_LOAD;
                    end
                end
                TGAP: begin
                    // The edge that ends the last gap period is evaluated as
                    // TIDLE, so exactly FRAME_GAP idle periods separate frames.
                    if (gap_q != '0)      gap_d      = gap_q - 1'b1;
                    else if (hold_full_q) tx_load    = 1'b1;
                    else                  tx_state_d = TIDLE;
                end
                default: tx_state_d = TIDLE;
            endcase
        end
        if (tx_load) begin
            tx_state_d = TSHIFT;
            tx_sh_d    = hold_q[SSP_WORD_W-2:0];
            rxd_d      = hold_q[SSP_WORD_W-1];
            fss_d      = 1'b1;
            tx_cnt_d   = SSP_CNT_W'(SSP_WORD_W - 1);
        end
    end

    // TX state register, SSPCLKIN divider and holding register.
    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            tx_state_q  <= TIDLE;
            clkin_q     <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_sh_q     <= '0;
            tx_cnt_q    <= '0;
            gap_q       <= '0;
            fss_q       <= 1'b0;
            rxd_q       <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            clkin_q     <= ~clkin_q;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_sh_q     <= tx_sh_d;
            tx_cnt_q    <= tx_cnt_d;
            gap_q       <= gap_d;
            fss_q       <= fss_d;
            rxd_q       <= rxd_d;
        end
    end

    // RX next-state: frame detect, bit capture, abort on output-enable loss.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_sh_d     = rx_sh_q;
        rx_cnt_d    = rx_cnt_q;
        rxbyte_d    = rxbyte_q;
        rx_complete = 1'b0;
        if (sample) begin
            case (rx_state_q)
                RIDLE: begin
                    if (bus.SSPFSSOUT && !bus.SSPOE_B) begin
                        rx_state_d = RSHIFT;
                        rx_cnt_d   = '0;
                    end
                end
                RSHIFT: begin
                    if (bus.SSPOE_B) begin
                        rx_state_d = RIDLE;
                        rx_cnt_d   = '0;
                    end else begin
                        rx_sh_d = {rx_sh_q[SSP_WORD_W-3:0], bus.SSPTXD};
                        if (rx_cnt_q == SSP_CNT_W'(SSP_WORD_W - 1)) begin
                            rx_complete = 1'b1;
                            rxbyte_d    = {rx_sh_q, bus.SSPTXD};
                            rx_cnt_d    = '0;
                            rx_state_d  = bus.SSPFSSOUT ? RSHIFT : RIDLE;
                        end else begin
                            rx_cnt_d = rx_cnt_q + 1'b1;
                        end
                    end
                end
                default: rx_state_d = RIDLE;
            endcase
        end
    end

    // A completing byte wins over a same-cycle acknowledge.
    assign rxvalid_d = rx_complete | (rxvalid_q & ~bus.RXACK);

    // RX state register and host-facing receive byte.
    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            rx_state_q <= RIDLE;
            rx_sh_q    <= '0;
            rx_cnt_q   <= '0;
            rxbyte_q   <= '0;
            rxvalid_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_sh_q    <= rx_sh_d;
            rx_cnt_q   <= rx_cnt_d;
            rxbyte_q   <= rxbyte_d;
            rxvalid_q  <= rxvalid_d;
        end
    end

`ifdef SSP_PERIPH_RXOVR_EN
    logic rxovr_q, rxovr_d;

    assign rxovr_d = rxovr_q | (rx_complete & rxvalid_q & ~bus.RXACK);

    // Sticky overrun flag, cleared only by reset.
    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) rxovr_q <= 1'b0;
        else          rxovr_q <= rxovr_d;
    end

    assign RXOVR = rxovr_q;
`endif

    assign bus.SSPCLKIN = clkin_q;
    assign bus.SSPFSSIN = fss_q;
    assign bus.SSPRXD   = rxd_q;
    assign bus.TXREADY  = ~hold_full_q;
    assign bus.RXBYTE   = rxbyte_q;
    assign bus.RXVALID  = rxvalid_q;

endmodule

// File: tb/tb_ssp_peripheral.sv
// Self-checking bench for ssp_peripheral: a FRAME_GAP=0 instance exercises
// TX, RX and reset; a FRAME_GAP=2 instance checks inter-frame gaps.
module tb_ssp_peripheral;

    logic PCLK = 1'b0;
    logic CLEAR_B = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 PCLK = ~PCLK;

    ssp_peripheral_if bus0 ();
    ssp_peripheral_if bus2 ();

`ifdef SSP_PERIPH_RXOVR_EN
    logic rxovr0, rxovr2;
`endif

    ssp_peripheral #(.FRAME_GAP(0)) dut0 (
        .PCLK    (PCLK),
        .CLEAR_B (CLEAR_B),
        .bus     (bus0)
`ifdef SSP_PERIPH_RXOVR_EN
        ,
        .RXOVR   (rxovr0)
`endif
    );

    ssp_peripheral #(.FRAME_GAP(2)) dut2 (
        .PCLK    (PCLK),
        .CLEAR_B (CLEAR_B),
        .bus     (bus2)
`ifdef SSP_PERIPH_RXOVR_EN
        ,
        .RXOVR   (rxovr2)
`endif
    );

    // the gap instance only transmits; its receive side is held idle
    assign bus2.SSPCLKOUT = 1'b0;
    assign bus2.SSPFSSOUT = 1'b0;
    assign bus2.SSPTXD    = 1'b0;
    assign bus2.SSPOE_B   = 1'b1;
    assign bus2.RXACK     = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- serial-output frame monitor (index 0: dut0, 1: dut2)
    logic [1:0] clkin_s, fss_s, rxd_s;
    assign clkin_s = {bus2.SSPCLKIN, bus0.SSPCLKIN};
    assign fss_s   = {bus2.SSPFSSIN, bus0.SSPFSSIN};
    assign rxd_s   = {bus2.SSPRXD,   bus0.SSPRXD};

    int         mon_n [2];
    int         mon_err [2];
    int         mon_bits [2];
    int         mon_idle [2];
    int         mon_curgap [2];
    bit         mon_inframe [2];
    logic [7:0] mon_sh [2];
    logic [7:0] mon_byte [2][64];
    int         mon_gap [2][64];

    always @(negedge PCLK) begin
        for (int d = 0; d < 2; d++) begin
            if (!CLEAR_B) begin
                mon_n[d] = 0; mon_err[d] = 0; mon_bits[d] = 0;
                mon_idle[d] = 1000; mon_inframe[d] = 0;
            end else if (clkin_s[d]) begin
                if (fss_s[d]) begin
                    if (mon_inframe[d]) mon_err[d]++;
                    mon_inframe[d] = 1; mon_bits[d] = 1;
                    mon_sh[d] = {7'b0, rxd_s[d]};
                    mon_curgap[d] = mon_idle[d];
                end else if (mon_inframe[d]) begin
                    mon_sh[d] = {mon_sh[d][6:0], rxd_s[d]};
                    mon_bits[d]++;
                    if (mon_bits[d] == 8) begin
                        if (mon_n[d] < 64) begin
                            mon_byte[d][mon_n[d]] = mon_sh[d];
                            mon_gap[d][mon_n[d]]  = mon_curgap[d];
                        end
                        mon_n[d]++; mon_inframe[d] = 0; mon_idle[d] = 0;
                    end
                end else begin
                    if (rxd_s[d]) mon_err[d]++;
                    mon_idle[d]++;
                end
            end
        end
    end

    // ---------------- host TX driver
    task automatic tx_send(input int d, input logic [7:0] b);
        int   t = 0;
        logic rdy;
        @(negedge PCLK);
        if (d == 0) begin bus0.TXBYTE = b; bus0.TXVALID = 1'b1; end
        else        begin bus2.TXBYTE = b; bus2.TXVALID = 1'b1; end
        rdy = (d == 0) ? bus0.TXREADY : bus2.TXREADY;
        while (!rdy && t < 200) begin
            @(negedge PCLK); t++;
            rdy = (d == 0) ? bus0.TXREADY : bus2.TXREADY;
        end
        check_eq("tx_accept", rdy, 1'b1);
        @(posedge PCLK); #1;
        if (d == 0) bus0.TXVALID = 1'b0; else bus2.TXVALID = 1'b0;
    endtask

    task automatic wait_frames(input int d, input int n, input string tag);
        int t = 0;
        while (mon_n[d] < n && t < 2000) begin @(posedge PCLK); t++; end
        check_eq(tag, mon_n[d], n);
    endtask

    // ---------------- SSP master model and RX reference
    logic [7:0] exp_byte = 8'h00;
    bit         exp_valid = 0;
    bit         exp_ovr = 0;

    task automatic m_period(input logic fss, input logic txd, input logic oe_b);
        @(posedge PCLK); #1;
        bus0.SSPCLKOUT = 1'b1; bus0.SSPFSSOUT = fss; bus0.SSPTXD = txd; bus0.SSPOE_B = oe_b;
        @(posedge PCLK); #1;
        bus0.SSPCLKOUT = 1'b0;
    endtask

    task automatic m_frame(input logic [7:0] b, input bit with_fss, input int abort_at,
                           input bit cont, input bit ack_last);
        if (with_fss) m_period(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == abort_at) begin
                m_period(1'b0, b[7-i], 1'b1);
                break;
            end
            m_period(cont && i == 7, b[7-i], 1'b0);
        end
        bus0.RXACK = ack_last;
        @(posedge PCLK); #1;
        bus0.RXACK = 1'b0; bus0.SSPFSSOUT = 1'b0; bus0.SSPOE_B = 1'b0;
    endtask

    task automatic model_rx(input logic [7:0] b, input bit ack_same);
        if (exp_valid && !ack_same) exp_ovr = 1;
        exp_valid = 1;
        exp_byte  = b;
    endtask

    task automatic rx_ack();
        @(negedge PCLK); bus0.RXACK = 1'b1;
        @(posedge PCLK); #1; bus0.RXACK = 1'b0;
        exp_valid = 0;
    endtask

    task automatic check_rx(input string tag);
        check_eq({tag, "_byte"}, bus0.RXBYTE, exp_byte);
        check_eq({tag, "_valid"}, bus0.RXVALID, exp_valid);
`ifdef SSP_PERIPH_RXOVR_EN
        check_eq({tag, "_ovr"}, rxovr0, exp_ovr);
`endif
    endtask

    // ---------------- stimulus
    initial begin
        logic [7:0] exp_tx [10];
        logic [7:0] b, b2;
        int         base, t;
        bit         ack_same;

        bus0.SSPCLKOUT = 0; bus0.SSPFSSOUT = 0; bus0.SSPTXD = 0; bus0.SSPOE_B = 0;
        bus0.TXBYTE = 0; bus0.TXVALID = 0; bus0.RXACK = 0;
        bus2.TXBYTE = 0; bus2.TXVALID = 0;

        #23;
        check_eq("rst_clkin", bus0.SSPCLKIN, 1'b0);
        check_eq("rst_fssin", bus0.SSPFSSIN, 1'b0);
        check_eq("rst_rxd", bus0.SSPRXD, 1'b0);
        check_eq("rst_txready", bus0.TXREADY, 1'b1);
        check_rx("rst");
        @(negedge PCLK); CLEAR_B = 1'b1;

        // single frame 0xA5
        tx_send(0, 8'hA5);
        wait_frames(0, 1, "a5_frames");
        check_eq("a5_byte", mon_byte[0][0], 8'hA5);

        // back-to-back frames on both gap settings
        base = mon_n[0];
        tx_send(0, 8'h3C); tx_send(0, 8'hC3);
        wait_frames(0, base + 2, "b2b_frames");
        check_eq("b2b_byte0", mon_byte[0][base], 8'h3C);
        check_eq("b2b_byte1", mon_byte[0][base+1], 8'hC3);
        check_eq("b2b_gap0", mon_gap[0][base+1], 0);
        base = mon_n[1];
        tx_send(1, 8'h3C); tx_send(1, 8'hC3);
        wait_frames(1, base + 2, "gap2_frames");
        check_eq("gap2_byte1", mon_byte[1][base+1], 8'hC3);
        check_eq("gap2_gap", mon_gap[1][base+1], 2);

        // random bytes with random host spacing
        base = mon_n[0];
        for (int i = 0; i < 10; i++) begin
            exp_tx[i] = 8'($urandom_range(0, 255));
            tx_send(0, exp_tx[i]);
            repeat ($urandom_range(0, 20)) @(posedge PCLK);
        end
        wait_frames(0, base + 10, "rnd_frames");
        for (int i = 0; i < 10; i++) check_eq("rnd_byte", mon_byte[0][base+i], exp_tx[i]);

        // random bytes queued continuously into the FRAME_GAP=2 instance
        base = mon_n[1];
        for (int i = 0; i < 6; i++) begin
            exp_tx[i] = 8'($urandom_range(0, 255));
            tx_send(1, exp_tx[i]);
        end
        wait_frames(1, base + 6, "rnd2_frames");
        for (int i = 0; i < 6; i++) begin
            check_eq("rnd2_byte", mon_byte[1][base+i], exp_tx[i]);
            if (i > 0) check_eq("rnd2_gap", mon_gap[1][base+i], 2);
        end
        check_eq("mon_err0", mon_err[0], 0);
        check_eq("mon_err2", mon_err[1], 0);

        // receive 0x81, hold until acknowledged
        m_frame(8'h81, 1, -1, 0, 0); model_rx(8'h81, 0);
        check_rx("rx81");
        repeat (10) @(posedge PCLK); #1;
        check_rx("rx81_hold");
        rx_ack(); check_rx("rx81_ack");
        rx_ack(); check_rx("stray_ack");

        // completion in the same cycle as an acknowledge
        m_frame(8'h6E, 1, -1, 0, 0); model_rx(8'h6E, 0);
        m_frame(8'h93, 1, -1, 0, 1); model_rx(8'h93, 1);
        check_rx("ack_same");
        rx_ack();

        // continuous frames: FSS at the last bit starts the next byte directly
        m_frame(8'hB4, 1, -1, 1, 0); model_rx(8'hB4, 0);
        check_rx("cont0");
        rx_ack();
        m_frame(8'h2D, 0, -1, 0, 0); model_rx(8'h2D, 0);
        check_rx("cont1");
        rx_ack();

        // overrun
        m_frame(8'h11, 1, -1, 0, 0); model_rx(8'h11, 0);
        m_frame(8'h22, 1, -1, 0, 0); model_rx(8'h22, 0);
        check_rx("ovr");
        rx_ack();

        // output enable lost after 4 bits, then a clean frame
        m_frame(8'h77, 1, 4, 0, 0);
        check_rx("abort");
        m_frame(8'h5A, 1, -1, 0, 0); model_rx(8'h5A, 0);
        check_rx("after_abort");
        rx_ack();

        // random receive traffic
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            ack_same = ($urandom_range(0, 3) == 0);
            m_frame(b, 1, -1, 0, ack_same); model_rx(b, ack_same);
            check_rx("rnd_rx");
            if ($urandom_range(0, 1) == 1) begin rx_ack(); check_rx("rnd_rx_ack"); end
        end
        check_eq("mon_err0_pre_rst", mon_err[0], 0);

        // reset in the middle of a TX frame and an RX frame
        b2 = 8'($urandom_range(0, 255));
        m_frame(b2, 1, -1, 0, 0); model_rx(b2, 0);
        fork
            m_frame(8'h99, 1, -1, 0, 0);
        join_none
        tx_send(0, 8'hFF);
        t = 0;
        while (!(mon_inframe[0] && mon_bits[0] >= 3) && t < 200) begin @(posedge PCLK); t++; end
        check_eq("rst_tx_started", mon_inframe[0] && mon_bits[0] >= 3, 1'b1);
        @(negedge PCLK); #2;
        CLEAR_B = 1'b0;
        #1;
        exp_valid = 0; exp_byte = 8'h00; exp_ovr = 0;
        check_eq("midrst_clkin", bus0.SSPCLKIN, 1'b0);
        check_eq("midrst_fssin", bus0.SSPFSSIN, 1'b0);
        check_eq("midrst_rxd", bus0.SSPRXD, 1'b0);
        check_eq("midrst_txready", bus0.TXREADY, 1'b1);
        check_rx("midrst");
        repeat (2) @(negedge PCLK);
        CLEAR_B = 1'b1;
        repeat (80) @(posedge PCLK); #1;
        check_eq("post_rst_frames", mon_n[0], 0);
        check_eq("post_rst_inframe", mon_inframe[0], 1'b0);
        check_eq("post_rst_err", mon_err[0], 0);
        check_eq("post_rst_txready", bus0.TXREADY, 1'b1);
        check_rx("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ssp_peripheral.md
SSP_PERIPHERAL -- requirements
Module: ssp_peripheral

Interface
REQ-001 Parameter FRAME_GAP, default 0: number of idle SSPCLKIN periods inserted between consecutive transmitted frames (0..15).
REQ-002 PCLK  in  1  sole clock; all state updates on posedge PCLK.
REQ-003 CLEAR_B  in  1  reset, asynchronous, active-low.
REQ-004 SSPCLKOUT  in  1  serial clock from SSP master, synchronous to PCLK, half PCLK rate.
REQ-005 SSPFSSOUT  in  1  master frame pulse.
REQ-006 SSPTXD  in  1  master serial data, MSB first.
REQ-007 SSPOE_B  in  1  master output enable, active-low.
REQ-008 SSPCLKIN  out  1  serial clock to master, PCLK/2.
REQ-009 SSPFSSIN  out  1  frame pulse to master.
REQ-010 SSPRXD  out  1  serial data to master, MSB first.
REQ-011 TXBYTE  in  8  host byte to send; TXVALID  in  1; TXREADY  out  1  (valid/ready handshake).
REQ-012 RXBYTE  out  8  last received byte; RXVALID  out  1  byte available; RXACK  in  1  host consumes byte.
REQ-013 RXOVR  out  1  sticky overrun flag (present only with SSP_PERIPH_RXOVR_EN).

Function
REQ-014 SSPCLKIN SHALL toggle on every PCLK posedge; a "TX edge" is the PCLK edge where it goes 0->1.
REQ-015 One-byte holding register: TXREADY = not full; TXVALID&TXREADY captures TXBYTE; capture and same-cycle unload of holding register SHALL both take effect.
REQ-016 TX FSM states TIDLE, TSHIFT, TGAP.
REQ-017 TIDLE: at a TX edge with holding full -> load shift register, SSPFSSIN=1, SSPRXD=bit7, bit count=7, go TSHIFT.
REQ-018 TSHIFT: each following TX edge drives next bit (6..0), SSPFSSIN=0; all outputs change only at TX edges.
REQ-019 After bit0 period: holding full and FRAME_GAP=0 -> next frame starts at the next TX edge with no gap; else TGAP for FRAME_GAP periods then TIDLE (FRAME_GAP=0 -> TIDLE directly).
REQ-020 SSPRXD and SSPFSSIN SHALL be 0 in TIDLE and TGAP.
REQ-021 Sample point = PCLK edge where registered SSPCLKOUT is 1 and live SSPCLKOUT is 0.
REQ-022 RX FSM states RIDLE, RSHIFT: RIDLE with SSPFSSOUT=1 and SSPOE_B=0 at a sample point -> RSHIFT; next 8 sample points capture SSPTXD as bits 7..0.
REQ-023 At the 8th bit sample: byte moved to RXBYTE, RXVALID=1 on the next PCLK; if SSPFSSOUT=1 at that sample, stay RSHIFT for a new frame, else RIDLE.
REQ-024 RXVALID SHALL hold until RXACK; RXACK with RXVALID=0 is ignored.
REQ-025 SSPOE_B high at any sample in RSHIFT -> discard partial byte, RIDLE, no RXVALID.
REQ-026 Byte completing while RXVALID=1 and no RXACK that cycle SHALL overwrite RXBYTE (overrun).
REQ-027 Byte completing in the same cycle as RXACK SHALL be presented with RXVALID remaining 1.

Reset
REQ-028 CLEAR_B low SHALL asynchronously force SSPCLKIN, SSPFSSIN, SSPRXD, RXVALID, RXOVR = 0, RXBYTE = 0, TXREADY = 1, both FSMs idle, holding empty, counters 0.
REQ-029 Reset mid-frame SHALL abort both directions with no partial RXVALID after release.

Configuration
REQ-030 Macro SSP_PERIPH_RXOVR_EN defined: RXOVR port exists; set on an overrun (REQ-026) and cleared only by reset; RXBYTE still overwritten.
REQ-031 Macro undefined: no RXOVR port or logic; overrun silently overwrites.

Structure
REQ-032 Package ssp_pkg SHALL hold SSP_WORD_W=8, the TX and RX state enumerations, and the FRAME_GAP maximum.
REQ-033 Sub-module ssp_edge_detect (registered SSPCLKOUT, rise/fall strobes) SHALL be instantiated once.

Verification
REQ-034 TXBYTE=0xA5 pulsed while idle -> SSPFSSIN high one SSPCLKIN period, SSPRXD 1,0,1,0,0,1,0,1 on successive TX edges.
REQ-035 0x3C then 0xC3 queued, FRAME_GAP=0 -> bit0 of 0x3C directly followed by FSS+MSB of 0xC3; FRAME_GAP=2 -> exactly 2 idle periods between.
REQ-036 Master sends 0x81 with SSPOE_B=0 -> RXBYTE=0x81, RXVALID high until RXACK, then low.
REQ-037 Two frames 0x11,0x22 with no RXACK -> RXBYTE=0x22; RXOVR=1 only with SSP_PERIPH_RXOVR_EN.
REQ-038 SSPOE_B raised after 4 bits -> no RXVALID; next full frame 0x5A received correctly.
REQ-039 CLEAR_B pulsed mid-TX of 0xFF -> all outputs 0 immediately, TXREADY=1, no residual frame after release.
